// File: rtl/mips_cpu_harvard_mc.sv
// Multi-cycle Harvard MIPS-I integer subset core with waitrequest handshakes on both buses.
// Build option MIPS_CPU_DELAY_SLOT_EN enables a single architectural branch delay slot.
module mips_cpu_harvard_mc #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int unsigned V0_INDEX        = 2,
  parameter logic [31:0] REG_RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic [31:0] instr_readdata,
  input  logic        instr_waitrequest,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  input  logic        data_waitrequest
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_STP   = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic            active_q, active_d;
  logic [XLEN-1:0] regs_q [NREG];

`ifdef MIPS_CPU_DELAY_SLOT_EN
  logic            pend_q, pend_d;
  logic [XLEN-1:0] target_q, target_d;
`endif

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            complete;
  logic            br_taken;
  logic [XLEN-1:0] br_target;

  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm16;
  logic [XLEN-1:0] rs_val, rt_val, simm, pc_plus4;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign rs_val   = regs_q[rs];
  assign rt_val   = regs_q[rt];
  assign simm     = {{16{imm16[15]}}, imm16};
  assign pc_plus4 = pc_q + 32'd4;

  // Bus strobes decode straight from the state so an async reset drops them at once.
  assign active         = active_q;
  assign register_v0    = regs_q[5'(V0_INDEX)];
  assign instr_address  = pc_q;
  assign instr_read     = (state_q == S_FETCH);
  assign data_address   = rs_val + simm;
  assign data_read      = (state_q == S_MEM) && (opcode == OP_LW);
  assign data_write     = (state_q == S_MEM) && (opcode == OP_SW);
  assign data_writedata = data_write ? rt_val : '0;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    active_d  = active_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = '0;
    complete  = 1'b0;
    br_taken  = 1'b0;
    br_target = pc_plus4;
`ifdef MIPS_CPU_DELAY_SLOT_EN
    pend_d    = pend_q;
    target_d  = target_q;
`endif

    case (state_q)
      S_START: begin
        active_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        if (!instr_waitrequest) begin
          ir_d    = instr_readdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d  = S_FETCH;
        complete = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            rf_waddr = rd;
            case (funct)
              FN_ADDU: begin rf_we = 1'b1; rf_wdata = rs_val + rt_val; end
              FN_SUBU: begin rf_we = 1'b1; rf_wdata = rs_val - rt_val; end
              FN_AND:  begin rf_we = 1'b1; rf_wdata = rs_val & rt_val; end
              FN_OR:   begin rf_we = 1'b1; rf_wdata = rs_val | rt_val; end
              FN_JR:   begin br_taken = 1'b1; br_target = rs_val; end
              default: ;
            endcase
          end
          OP_ADDIU: begin rf_we = 1'b1; rf_wdata = rs_val + simm; end
          OP_ORI:   begin rf_we = 1'b1; rf_wdata = rs_val | {16'h0, imm16}; end
          OP_LUI:   begin rf_we = 1'b1; rf_wdata = {imm16, 16'h0}; end
          OP_BEQ: begin
            br_taken  = (rs_val == rt_val);
            br_target = pc_plus4 + {simm[29:0], 2'b00};
          end
          OP_BNE: begin
            br_taken  = (rs_val != rt_val);
            br_target = pc_plus4 + {simm[29:0], 2'b00};
          end
          OP_J: begin
            br_taken  = 1'b1;
            br_target = {pc_plus4[31:28], ir_q[25:0], 2'b00};
          end
          OP_LW, OP_SW: begin
            state_d  = S_MEM;
            complete = 1'b0;
          end
          OP_STP: begin
            state_d  = S_HALT;
            active_d = 1'b0;
            complete = 1'b0;
`ifdef MIPS_CPU_DELAY_SLOT_EN
            pend_d   = 1'b0;
`endif
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (!data_waitrequest) begin
          state_d  = S_FETCH;
          complete = 1'b1;
          if (opcode == OP_LW) begin
            rf_we    = 1'b1;
            rf_wdata = data_readdata;
          end
        end
      end
      S_HALT: active_d = 1'b0;
      default: state_d = S_START;
    endcase

    // A finished instruction in the delay slot redirects to the latest pending target.
    if (complete) begin
`ifdef MIPS_CPU_DELAY_SLOT_EN
      if (pend_q) begin
        pc_d   = br_taken ? br_target : target_q;
        pend_d = 1'b0;
      end else if (br_taken) begin
        pc_d     = pc_plus4;
        pend_d   = 1'b1;
        target_d = br_target;
      end else begin
        pc_d = pc_plus4;
      end
`else
      pc_d = br_taken ? br_target : pc_plus4;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_START;
      pc_q     <= RESET_VECTOR;
      ir_q     <= '0;
      active_q <= 1'b0;
`ifdef MIPS_CPU_DELAY_SLOT_EN
      pend_q   <= 1'b0;
      target_q <= '0;
`endif
    end else if (clk_enable) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      active_q <= active_d;
`ifdef MIPS_CPU_DELAY_SLOT_EN
      pend_q   <= pend_d;
      target_q <= target_d;
`endif
    end
  end

  // Register file; entry 0 is reset to zero and never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == 0) ? '0 : REG_RESET_VALUE;
      end
    end else if (clk_enable && rf_we && (rf_waddr != 5'd0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule
